// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit.
// Holds the opcode classes it recognises, the default address width and the
// layout of one queued fetch-time prediction.
package branch_resolve_unit_pkg;

    localparam int BRU_ADDR_W = 8;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef struct packed {
        logic [BRU_ADDR_W-1:0] addr;
        logic                  taken;
        logic [BRU_ADDR_W-1:0] target;
    } pred_entry_t;

    function automatic logic is_jump_op(input logic [6:0] op);
        return (op == OP_JAL) || (op == OP_JALR);
    endfunction

endpackage

// File: rtl/branch_resolve_unit_fifo.sv
// bru_pred_fifo: in-order queue of fetch-time predictions.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push, push_entry  write one entry (ignored when full)
//   pop               drop the head entry (ignored when empty)
//   clear             drop everything; wins over a same-cycle push
//   full, empty       occupancy flags from the registered count
//   head              oldest entry, valid while empty=0
//   count             current occupancy
module bru_pred_fifo
    import branch_resolve_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  pred_entry_t                push_entry,
    input  logic                       pop,
    input  logic                       clear,
    output logic                       full,
    output logic                       empty,
    output pred_entry_t                head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    pred_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push && !rst && !clear) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: queues fetch-time predictions and checks the oldest one
// against the execute-stage outcome; trains the predictor and flushes on a
// mispredict.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   pred_valid/addr/taken/target  prediction push from fetch
//   pred_ready                    push accepted this cycle (!full && !flush)
//   res_valid/opcode/taken/target execute-stage resolution of the oldest branch
//   update, update_address, branch_taken, opcode   predictor training (1-cycle)
//   flush, redirect_pc            one-cycle flush and the correct next PC
//   mispredict_cnt                saturating mispredict count
//   underflow_err                 sticky: resolution seen with nothing queued
// ADDR_W must match the package address width used by the queue entries.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int ADDR_W = BRU_ADDR_W,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pred_valid,
    input  logic [ADDR_W-1:0] pred_addr,
    input  logic              pred_taken,
    input  logic [ADDR_W-1:0] pred_target,
    output logic              pred_ready,
    input  logic              res_valid,
    input  logic [6:0]        res_opcode,
    input  logic              res_taken,
    input  logic [ADDR_W-1:0] res_target,
    output logic              update,
    output logic [ADDR_W-1:0] update_address,
    output logic              branch_taken,
    output logic [6:0]        opcode,
    output logic              flush,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [CNT_W-1:0]  mispredict_cnt,
    output logic              underflow_err
);

    pred_entry_t                push_entry;
    pred_entry_t                head;
    logic                       full;
    logic                       empty;
    logic [$clog2(DEPTH+1)-1:0] count;
    logic                       do_push;
    logic                       do_pop;
    logic                       is_branch;
    logic                       is_jump;
    logic                       mispredict;
    logic                       resolve_mis;

    assign pred_ready = !full && !flush;
    assign do_push    = pred_valid && pred_ready;
    assign do_pop     = res_valid && !empty;
    assign resolve_mis = do_pop && mispredict;

    assign push_entry.addr   = pred_addr;
    assign push_entry.taken  = pred_taken;
    assign push_entry.target = pred_target;

    always_comb begin
        is_branch  = (res_opcode == OP_BRANCH);
        is_jump    = is_jump_op(res_opcode);
        mispredict = 1'b0;
        if (is_branch) begin
            // Not-taken branches carry a don't-care predicted target.
            mispredict = (head.taken != res_taken) ||
                         (res_taken && (head.target != res_target));
        end else if (is_jump) begin
            mispredict = !head.taken || (head.target != res_target);
        end
    end

    // Clearing on the mispredict edge also discards a push accepted in the
    // same cycle, since everything younger than the head is wrong-path.
    bru_pred_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (do_push),
        .push_entry (push_entry),
        .pop        (do_pop),
        .clear      (resolve_mis),
        .full       (full),
        .empty      (empty),
        .head       (head),
        .count      (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            update         <= 1'b0;
            update_address <= '0;
            branch_taken   <= 1'b0;
            opcode         <= '0;
            flush          <= 1'b0;
            redirect_pc    <= '0;
            mispredict_cnt <= '0;
            underflow_err  <= 1'b0;
        end else begin
            update <= do_pop && (is_branch || is_jump);
            flush  <= resolve_mis;
            if (do_pop && (is_branch || is_jump)) begin
                update_address <= head.addr;
                branch_taken   <= res_taken;
                opcode         <= res_opcode;
            end
            if (resolve_mis) begin
                redirect_pc <= res_target;
                if (mispredict_cnt != {CNT_W{1'b1}})
                    mispredict_cnt <= mispredict_cnt + 1'b1;
            end
            if (res_valid && empty)
                underflow_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit. Expected predictor/flush responses
// are queued when a resolution is issued; a monitor pops and compares them
// whenever the unit presents update or flush.
module tb_branch_resolve_unit;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 2;

    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_ALU  = 7'b0010011;

    logic              clk = 1'b0;
    logic              rst;
    logic              pred_valid;
    logic [ADDR_W-1:0] pred_addr;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
    logic              pred_ready;
    logic              res_valid;
    logic [6:0]        res_opcode;
    logic              res_taken;
    logic [ADDR_W-1:0] res_target;
    logic              update;
    logic [ADDR_W-1:0] update_address;
    logic              branch_taken;
    logic [6:0]        opcode;
    logic              flush;
    logic [ADDR_W-1:0] redirect_pc;
    logic [CNT_W-1:0]  mispredict_cnt;
    logic              underflow_err;

    typedef struct {
        logic              upd;
        logic [ADDR_W-1:0] addr;
        logic              tk;
        logic [6:0]        op;
        logic              fl;
        logic [ADDR_W-1:0] rpc;
        logic [CNT_W-1:0]  cnt;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .pred_valid     (pred_valid),
        .pred_addr      (pred_addr),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .pred_ready     (pred_ready),
        .res_valid      (res_valid),
        .res_opcode     (res_opcode),
        .res_taken      (res_taken),
        .res_target     (res_target),
        .update         (update),
        .update_address (update_address),
        .branch_taken   (branch_taken),
        .opcode         (opcode),
        .flush          (flush),
        .redirect_pc    (redirect_pc),
        .mispredict_cnt (mispredict_cnt),
        .underflow_err  (underflow_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_out(input logic fl, input logic [ADDR_W-1:0] addr, input logic tk,
                              input logic [6:0] op, input logic [ADDR_W-1:0] rpc,
                              input logic [CNT_W-1:0] cnt);
        exp_t e;
        e.upd = 1'b1; e.addr = addr; e.tk = tk; e.op = op; e.fl = fl; e.rpc = rpc; e.cnt = cnt;
        sb.push_back(e);
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (update === 1'b1 || flush === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", {30'd0, update, flush}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("update",         32'(update),         32'(e.upd));
                    check("update_address", 32'(update_address), 32'(e.addr));
                    check("branch_taken",   32'(branch_taken),   32'(e.tk));
                    check("opcode",         32'(opcode),         32'(e.op));
                    check("flush",          32'(flush),          32'(e.fl));
                    check("redirect_pc",    32'(redirect_pc),    32'(e.rpc));
                    check("mispredict_cnt", 32'(mispredict_cnt), 32'(e.cnt));
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [ADDR_W-1:0] a, input logic t, input logic [ADDR_W-1:0] tg);
        pred_valid = 1'b1; pred_addr = a; pred_taken = t; pred_target = tg;
        @(posedge clk);
        #1;
        pred_valid = 1'b0;
    endtask

    task automatic resolve(input logic [6:0] op, input logic t, input logic [ADDR_W-1:0] tg,
                           input logic with_push, input logic [ADDR_W-1:0] pa);
        res_valid = 1'b1; res_opcode = op; res_taken = t; res_target = tg;
        pred_valid = with_push; pred_addr = pa; pred_taken = 1'b0; pred_target = 8'h00;
        @(posedge clk);
        #1;
        res_valid = 1'b0; pred_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        @(negedge clk);
        check({tag, "_update"},    32'(update),         32'd0);
        check({tag, "_flush"},     32'(flush),          32'd0);
        check({tag, "_upd_addr"},  32'(update_address), 32'd0);
        check({tag, "_br_taken"},  32'(branch_taken),   32'd0);
        check({tag, "_opcode"},    32'(opcode),         32'd0);
        check({tag, "_redirect"},  32'(redirect_pc),    32'd0);
        check({tag, "_cnt"},       32'(mispredict_cnt), 32'd0);
        check({tag, "_underflow"}, 32'(underflow_err),  32'd0);
        check({tag, "_ready"},     32'(pred_ready),     32'd1);
        check({tag, "_occupancy"}, 32'(u_dut.u_fifo.count), 32'd0);
        #1;
    endtask

    initial begin
        rst = 1'b1; pred_valid = 1'b0; pred_addr = '0; pred_taken = 1'b0; pred_target = '0;
        res_valid = 1'b0; res_opcode = '0; res_taken = 1'b0; res_target = '0;
        do_reset();
        check_all_zero("reset");

        // 1: correctly predicted taken branch
        push(8'h04, 1'b1, 8'h20);
        expect_out(1'b0, 8'h04, 1'b1, OP_B, 8'h00, 2'd0);
        resolve(OP_B, 1'b1, 8'h20, 1'b0, 8'h00);
        idle(1);

        // 2: direction mispredict; younger entries plus a same-cycle push are discarded,
        //    and a push held during the flush cycle is refused
        push(8'h08, 1'b0, 8'h00);
        push(8'h0c, 1'b1, 8'h50);
        push(8'h10, 1'b0, 8'h00);
        expect_out(1'b1, 8'h08, 1'b1, OP_B, 8'h40, 2'd1);
        resolve(OP_B, 1'b1, 8'h40, 1'b1, 8'h14);
        check("flush_ready", 32'(pred_ready), 32'd0);
        push(8'h18, 1'b0, 8'h00);
        check("occ_after_flush", 32'(u_dut.u_fifo.count), 32'd0);

        // 3: fill, overflow drop, refused push alongside a pop
        push(8'h40, 1'b0, 8'h00);
        push(8'h44, 1'b0, 8'h00);
        push(8'h48, 1'b0, 8'h00);
        push(8'h4c, 1'b0, 8'h00);
        check("full_ready", 32'(pred_ready), 32'd0);
        push(8'h50, 1'b0, 8'h00);
        check("occ_after_drop", 32'(u_dut.u_fifo.count), 32'd4);
        expect_out(1'b0, 8'h40, 1'b0, OP_B, 8'h40, 2'd1);
        resolve(OP_B, 1'b0, 8'h44, 1'b1, 8'h54);
        check("occ_pop_push_full", 32'(u_dut.u_fifo.count), 32'd3);
        // Non-control opcodes pop silently; entry 0x44 resolved next would be
        // the head, so draining in order proves the refused 0x54 never entered.
        resolve(OP_ALU, 1'b0, 8'h00, 1'b0, 8'h00);
        resolve(OP_ALU, 1'b0, 8'h00, 1'b0, 8'h00);
        resolve(OP_ALU, 1'b0, 8'h00, 1'b0, 8'h00);
        check("occ_drained", 32'(u_dut.u_fifo.count), 32'd0);
        check("no_underflow_yet", 32'(underflow_err), 32'd0);

        // 4: JALR target mispredict
        push(8'h10, 1'b1, 8'h30);
        expect_out(1'b1, 8'h10, 1'b1, OP_JALR, 8'h34, 2'd2);
        resolve(OP_JALR, 1'b1, 8'h34, 1'b0, 8'h00);
        idle(1);

        // 5: underflow (empty queue with a same-cycle push), sticky until reset
        resolve(OP_B, 1'b1, 8'h22, 1'b1, 8'h60);
        check("underflow_set", 32'(underflow_err), 32'd1);
        check("occ_underflow_push", 32'(u_dut.u_fifo.count), 32'd1);
        idle(3);
        check("underflow_sticky", 32'(underflow_err), 32'd1);
        do_reset();
        check_all_zero("reset2");

        // 6: counter saturation with CNT_W=2
        for (int i = 0; i < 4; i++) begin
            push(8'(8'h70 + 4 * i), 1'b0, 8'h00);
            expect_out(1'b1, 8'(8'h70 + 4 * i), 1'b1, OP_B, 8'(8'h90 + 4 * i),
                       (i < 3) ? 2'(i + 1) : 2'd3);
            resolve(OP_B, 1'b1, 8'(8'h90 + 4 * i), 1'b0, 8'h00);
            idle(1);
        end
        check("cnt_saturated", 32'(mispredict_cnt), 32'd3);

        push(8'ha0, 1'b0, 8'h00);
        push(8'ha4, 1'b0, 8'h00);
        push(8'ha8, 1'b0, 8'h00);
        check("occ_before_rst", 32'(u_dut.u_fifo.count), 32'd3);
        do_reset();
        check_all_zero("reset3");

        idle(3);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1);
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Downstream partner of gshare_predictor; sits between fetch-side prediction and the execute stage.
- Queues each fetch-time prediction (address, direction, target) in order, then compares the oldest entry with the execute-stage outcome.
- Drives the predictor's update interface (update, update_address, branch_taken, opcode) and issues a one-cycle flush/redirect on mispredict.
- Keeps a saturating mispredict counter for performance reporting.

Parameters:
- ADDR_W, 8, instruction address width; matches the predictor's branch_address.
- DEPTH, 4, in-flight prediction queue entries; power of two, at least 2.
- CNT_W, 16, mispredict counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- pred_valid  in  1  fetch pushes a prediction.
- pred_addr  in  ADDR_W  address of the predicted branch.
- pred_taken  in  1  predicted direction (the predictor's prediction output).
- pred_target  in  ADDR_W  predicted target; don't-care when pred_taken=0.
- pred_ready  out  1  queue can accept; equals !full && !flush.
- res_valid  in  1  execute resolves the oldest in-flight branch.
- res_opcode  in  7  opcode of the resolved instruction.
- res_taken  in  1  actual direction.
- res_target  in  ADDR_W  actual target; next sequential PC when res_taken=0.
- update  out  1  one-cycle predictor update strobe.
- update_address  out  ADDR_W  address being trained.
- branch_taken  out  1  actual outcome sent to the predictor.
- opcode  out  7  registered copy of res_opcode, sent to the predictor.
- flush  out  1  one-cycle pipeline flush.
- redirect_pc  out  ADDR_W  correct next PC, valid while flush=1.
- mispredict_cnt  out  CNT_W  saturating count of mispredicts.
- underflow_err  out  1  sticky; set when res_valid arrives with the queue empty.

Behaviour:
Reset (synchronous, rst=1 at a clock edge):
- Queue emptied; pointers and occupancy cleared.
- update, flush, underflow_err and mispredict_cnt go to 0.
- update_address, branch_taken, opcode and redirect_pc go to 0.
- rst mid-operation drops all in-flight entries. No update or flush is emitted in the cycle after reset.

Enqueue:
- Occurs on a clock edge where pred_valid && pred_ready.
- Stores {pred_addr, pred_taken, pred_target}.
- pred_valid while full, or while flush=1, is discarded and does not count.

Dequeue and resolve:
- Occurs on an edge where res_valid=1 and the queue is non-empty (evaluated before that cycle's enqueue).
- The head entry is popped and compared with the outcome.
- Opcode classes:
  - B-type 1100011: mispredict = (pred_taken != res_taken) || (res_taken && pred_target != res_target).
  - JAL 1101111, JALR 1100111: mispredict = !pred_taken || pred_target != res_target.
  - Any other opcode: entry is popped, no update, no mispredict.
- Same-cycle enqueue:
  - A pop and a push in the same cycle are both performed when not full at the start of the cycle.
  - When full, the push is refused even if a pop occurs that cycle (pred_ready is combinational on registered full).

Outputs:
- Latency is one cycle: resolution in cycle N gives registered outputs in cycle N+1.
- update=1 for B, JAL and JALR resolutions. update_address = head pred_addr, branch_taken = res_taken, opcode = res_opcode.
- On mispredict: flush=1 for exactly one cycle, redirect_pc = res_target, and mispredict_cnt increments, saturating at all-ones.
- The edge that registers flush=1 also clears the queue, including any push accepted in cycle N, because those entries are wrong-path.
- Pushes during the flush cycle are refused.

Underflow:
- res_valid with the queue empty (including an empty queue plus a same-cycle push) is ignored.
- underflow_err is set and stays set until reset.

Decomposition:
- Shared package holds:
  - opcode constants OP_BRANCH=7'b1100011, OP_JAL=7'b1101111, OP_JALR=7'b1100111;
  - ADDR_W default;
  - a packed pred_entry_t struct {addr, taken, target}.
- One natural sub-module: bru_pred_fifo, a synchronous FIFO of pred_entry_t with push, pop, clear, full, empty and head.
- The compare and output register logic stays in the top level.

Test Plan:
1. Reset, then push {addr=0x04, taken=1, target=0x20}, then resolve B-type taken=1 target=0x20 -> next cycle update=1, update_address=0x04, branch_taken=1, flush=0, mispredict_cnt=0.
2. Push {0x08, taken=0}, resolve B-type taken=1 target=0x40 -> update=1, flush=1 for one cycle, redirect_pc=0x40, mispredict_cnt=1. The queue holding 2 younger entries is cleared (empty=1 after the flush cycle).
3. Push 4 entries -> pred_ready=0. A 5th push is dropped. Resolve once with a simultaneous push -> push refused, occupancy 3.
4. Push JALR {0x10, taken=1, target=0x30}, resolve res_target=0x34 -> flush=1, redirect_pc=0x34, update=1, opcode=1100111.
5. res_valid with the queue empty -> no update, no flush, underflow_err=1 and stays high. Assert rst -> underflow_err=0.
6. Preload mispredict_cnt near saturation (or use CNT_W=2) and force 4 mispredicts -> counter holds at 3. Assert rst while 3 entries are queued -> all outputs 0, queue empty.
